// File: rtl/fabric_spi_transmitter.sv
// SPI (CPOL=0, MSB first) word transmitter feeding fabric_spi_receiver.
// One-entry holding buffer lets consecutive words stream under a single CS_N.
module fabric_spi_transmitter #(
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        busy_o,
  output logic        sclk_o,
  output logic        cs_no,
  output logic        mosi_o,
  input  logic        miso_i
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned PH_W   = 8;

  if (HALF_PERIOD < 2 || HALF_PERIOD > 255) begin : g_half_period_check
    $error("fabric_spi_transmitter: HALF_PERIOD must be in 2..255");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOW   = 3'd1,
    HIGH  = 3'd2,
    TRAIL = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic                hold_valid_q, hold_valid_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [PH_W-1:0]     phase_cnt_q, phase_cnt_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic                mosi_q, mosi_d;

  logic                phase_done;
  logic                start_ok;
  logic                load;
  logic                unused_miso;

  assign unused_miso = miso_i;
  assign phase_done  = (phase_cnt_q == PH_W'(HALF_PERIOD - 1));
  assign start_ok    = hold_valid_q && enable_i;

  // Next-state and datapath decode
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    phase_cnt_d  = phase_cnt_q;
    sclk_d       = sclk_q;
    cs_n_d       = cs_n_q;
    mosi_d       = mosi_q;
    load         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          load        = 1'b1;
          shift_d     = hold_q;
          cs_n_d      = 1'b0;
          bit_cnt_d   = '0;
          phase_cnt_d = '0;
          state_d     = LOW;
        end
      end
      LOW: begin
        if (phase_done) begin
          phase_cnt_d = '0;
          sclk_d      = 1'b1;
          mosi_d      = shift_q[WORD_W-1];
          state_d     = HIGH;
        end else begin
          phase_cnt_d = phase_cnt_q + PH_W'(1);
        end
      end
      HIGH: begin
        if (phase_done) begin
          phase_cnt_d = '0;
          sclk_d      = 1'b0;
          if (bit_cnt_q != CNT_W'(WORD_W - 1)) begin
            shift_d   = {shift_q[WORD_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            state_d   = LOW;
          end else if (start_ok) begin
            // Chain the next word without releasing CS_N; SCLK stays periodic
            load      = 1'b1;
            shift_d   = hold_q;
            bit_cnt_d = '0;
            state_d   = LOW;
          end else begin
            state_d   = TRAIL;
          end
        end else begin
          phase_cnt_d = phase_cnt_q + PH_W'(1);
        end
      end
      TRAIL: begin
        if (phase_done) begin
          phase_cnt_d = '0;
          cs_n_d      = 1'b1;
          mosi_d      = 1'b0;
          state_d     = GAP;
        end else begin
          phase_cnt_d = phase_cnt_q + PH_W'(1);
        end
      end
      GAP: begin
        if (phase_done) begin
          phase_cnt_d = '0;
          state_d     = IDLE;
        end else begin
          phase_cnt_d = phase_cnt_q + PH_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Holding buffer: accept only when empty, so accept and load never collide
    if (valid_i && !hold_valid_q) begin
      hold_d       = data_i;
      hold_valid_d = 1'b1;
    end else if (load) begin
      hold_valid_d = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      phase_cnt_q  <= '0;
      sclk_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      mosi_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      phase_cnt_q  <= phase_cnt_d;
      sclk_q       <= sclk_d;
      cs_n_q       <= cs_n_d;
      mosi_q       <= mosi_d;
    end
  end

  assign sclk_o  = sclk_q;
  assign cs_no   = cs_n_q;
  assign mosi_o  = mosi_q;
  assign ready_o = !hold_valid_q;
  assign busy_o  = (state_q != IDLE) || hold_valid_q;

endmodule

// File: tb/tb_fabric_spi_transmitter.sv
// Scoreboard bench: words pushed on handshake, popped by an SPI receiver monitor
// that also checks SCLK/CS_N/MOSI timing rules.
module tb_fabric_spi_transmitter;

  localparam int unsigned HP    = 4;
  localparam int          LIMIT = 5000;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        enable_i = 1'b1;
  logic [31:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o, busy_o, sclk_o, cs_no, mosi_o;
  logic        miso_i = 1'b0;

  fabric_spi_transmitter #(.HALF_PERIOD(HP)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .data_i(data_i),
    .valid_i(valid_i), .ready_o(ready_o), .busy_o(busy_o), .sclk_o(sclk_o),
    .cs_no(cs_no), .mosi_o(mosi_o), .miso_i(miso_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Receiver model and timing monitor
  int          cyc = 0, last_fall = 0, cs_fall_cyc = 0, cs_high_cnt = HP;
  int          nbits = 0, falls_total = 0, cs_rises = 0, rx_cnt = 0;
  bit          fall_seen = 0, rise_seen = 0;
  logic        p_sclk = 1'b0, p_cs = 1'b1, p_mosi = 1'b0;
  logic [31:0] word = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_ni) begin
      nbits = 0; fall_seen = 0; rise_seen = 0; cs_high_cnt = HP;
    end else begin
      if (sclk_o != p_sclk) chk("sclk_toggle_needs_cs_low", 32'(cs_no), 32'd0);
      if (mosi_o != p_mosi)
        chk("mosi_change_on_rise_only", 32'((!p_sclk && sclk_o) || (!p_cs && cs_no)), 32'd1);
      if (p_cs && !cs_no) begin
        chk("cs_high_time_min", 32'(cs_high_cnt >= int'(HP)), 32'd1);
        cs_fall_cyc = cyc; fall_seen = 0; rise_seen = 0;
      end
      if (cs_no) cs_high_cnt++; else cs_high_cnt = 0;
      if (!p_sclk && sclk_o && !rise_seen) begin
        chk("first_rise_delay", 32'(cyc - cs_fall_cyc), 32'(HP));
        rise_seen = 1;
      end
      if (p_sclk && !sclk_o) begin
        if (fall_seen) chk("fall_period", 32'(cyc - last_fall), 32'(2 * HP));
        fall_seen = 1; last_fall = cyc; falls_total++;
        word = {word[30:0], mosi_o};
        nbits++;
        if (nbits == 32) begin
          nbits = 0; rx_cnt++;
          if (exp_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL rx_word: got %h expected none (queue empty)", word);
          end else begin
            chk("rx_word", word, exp_q.pop_front());
          end
        end
      end
      if (!p_cs && cs_no) begin
        chk("cs_rise_after_last_fall", 32'(cyc - last_fall), 32'(HP));
        chk("bits_at_cs_rise", 32'(nbits), 32'd0);
        cs_rises++;
      end
    end
    p_sclk = sclk_o; p_cs = cs_no; p_mosi = mosi_o;
  end

  // Call at a negedge; leaves valid_i high at the negedge after the handshake
  task automatic send(input logic [31:0] d);
    int n = 0;
    valid_i = 1'b1; data_i = d;
    while (!ready_o && n < LIMIT) begin @(negedge clk); n++; end
    chk("send_accept", 32'(ready_o), 32'd1);
    if (ready_o) exp_q.push_back(d);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_o || exp_q.size() != 0) && n < LIMIT) begin @(negedge clk); n++; end
    chk("drain_busy", 32'(busy_o), 32'd0);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int r0, c0, f0, n, gap;
    logic [31:0] w;

    repeat (3) @(negedge clk);
    chk("rst_sclk", 32'(sclk_o), 32'd0);
    chk("rst_cs", 32'(cs_no), 32'd1);
    chk("rst_mosi", 32'(mosi_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);

    // Single word with acceptance-to-CS latency
    r0 = rx_cnt;
    send(32'hA5C30F01); valid_i = 1'b0;
    chk("cs_high_after_accept", 32'(cs_no), 32'd1);
    repeat (2) @(negedge clk);
    chk("cs_low_2nd_edge", 32'(cs_no), 32'd0);
    wait_idle();
    chk("single_rx_count", 32'(rx_cnt - r0), 32'd1);

    // Back-to-back pair under one CS_N
    r0 = rx_cnt; c0 = cs_rises;
    send(32'h00000001); send(32'hFFFFFFFE); valid_i = 1'b0;
    wait_idle();
    chk("pair_rx_count", 32'(rx_cnt - r0), 32'd2);
    chk("pair_one_frame", 32'(cs_rises - c0), 32'd1);

    // Three words continuously
    r0 = rx_cnt; c0 = cs_rises;
    send(32'hDEADBEEF); send(32'h0BADF00D);
    chk("ready_low_after_2nd", 32'(ready_o), 32'd0);
    send(32'hCAFEF00D); valid_i = 1'b0;
    wait_idle();
    chk("triple_rx_count", 32'(rx_cnt - r0), 32'd3);
    chk("triple_one_frame", 32'(cs_rises - c0), 32'd1);

    // Enable gating
    enable_i = 1'b0;
    send(32'h5A5A0001); valid_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("dis_ready", 32'(ready_o), 32'd0);
    chk("dis_busy", 32'(busy_o), 32'd1);
    chk("dis_cs", 32'(cs_no), 32'd1);
    enable_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("en_cs_low", 32'(cs_no), 32'd0);
    wait_idle();

    // Reset mid-frame after the 10th falling edge
    f0 = falls_total;
    send(32'h87654321); valid_i = 1'b0;
    n = 0;
    while (falls_total < f0 + 10 && n < LIMIT) begin @(negedge clk); #1; n++; end
    chk("reached_10_falls", 32'(falls_total >= f0 + 10), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("arst_sclk", 32'(sclk_o), 32'd0);
    chk("arst_cs", 32'(cs_no), 32'd1);
    chk("arst_mosi", 32'(mosi_o), 32'd0);
    chk("arst_ready", 32'(ready_o), 32'd1);
    chk("arst_busy", 32'(busy_o), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    r0 = rx_cnt; f0 = falls_total;
    send(32'h12345678); valid_i = 1'b0;
    wait_idle();
    chk("post_rst_rx", 32'(rx_cnt - r0), 32'd1);
    chk("post_rst_falls", 32'(falls_total - f0), 32'd32);

    // Randomized traffic with gaps and enable drops
    r0 = rx_cnt;
    for (int i = 0; i < 16; i++) begin
      enable_i = 1'b1;
      w = $urandom;
      send(w);
      gap = $urandom_range(0, 3);
      if (gap > 0) begin valid_i = 1'b0; repeat (gap) @(negedge clk); end
      if ($urandom_range(0, 3) == 0) begin
        valid_i = 1'b0; enable_i = 1'b0;
        repeat ($urandom_range(1, 300)) @(negedge clk);
        enable_i = 1'b1;
      end
    end
    valid_i = 1'b0; enable_i = 1'b1;
    wait_idle();
    chk("rand_rx_count", 32'(rx_cnt - r0), 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
